// File: rtl/adc_dout_capture.sv
// adc_dout_capture: receive side of the touch-panel ADC serial link.
// Deserialises the Y and X 12-bit results of each frame from ADC_DOUT, using the shared
// COUNT/ENABLE frame counter for timing. It publishes the pair atomically with a one-CLK
// DATA_VALID pulse, unless the pen was lifted at any point during capture.
module adc_dout_capture #(
  parameter int unsigned Y_FIRST = 19,
  parameter int unsigned X_FIRST = 51,
  parameter int unsigned NBITS   = 12
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             ENABLE,
  input  logic [6:0]       COUNT,
  input  logic             ADC_DOUT,
  input  logic             PENIRQ_n,
  output logic [NBITS-1:0] Y_COORD,
  output logic [NBITS-1:0] X_COORD,
  output logic             DATA_VALID,
  output logic             PEN_DOWN
);

  localparam int unsigned CntW = $clog2(NBITS + 1);

  typedef enum logic [2:0] {
    StIdle,
    StCapY,
    StWaitX,
    StCapX,
    StPublish
  } state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [NBITS-1:0] y_hold_q, y_hold_d;
  logic             pen_lost_q, pen_lost_d;
  logic [NBITS-1:0] y_coord_q, y_coord_d;
  logic [NBITS-1:0] x_coord_q, x_coord_d;
  logic             data_valid_q, data_valid_d;
  logic             penirq_meta_q, penirq_sync_q;

  logic             frame_start;
  logic             last_bit;
  logic             y_sample;
  logic             x_sample;
  logic             x_first;
  logic [NBITS-1:0] shift_in;
  logic [6:0]       bit_offset;

  // Pen interrupt synchroniser; resets to "pen up" so PEN_DOWN starts low.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      penirq_meta_q <= 1'b1;
      penirq_sync_q <= 1'b1;
    end else begin
      penirq_meta_q <= PENIRQ_n;
      penirq_sync_q <= penirq_meta_q;
    end
  end

  assign PEN_DOWN = ~penirq_sync_q;

  // Sample points: window start + 2 * bits already taken.
  always_comb begin
    bit_offset  = 7'({bit_cnt_q, 1'b0});
    frame_start = ENABLE && (COUNT == 7'd0);
    last_bit    = (bit_cnt_q == CntW'(NBITS - 1));
    y_sample    = ENABLE && (COUNT == 7'(Y_FIRST) + bit_offset);
    x_sample    = ENABLE && (COUNT == 7'(X_FIRST) + bit_offset);
    x_first     = ENABLE && (COUNT == 7'(X_FIRST));
    shift_in    = {shift_q[NBITS-2:0], ADC_DOUT};
  end

  // Next-state and datapath: capture Y, hold it, capture X, then publish both together.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    y_hold_d     = y_hold_q;
    pen_lost_d   = pen_lost_q;
    y_coord_d    = y_coord_q;
    x_coord_d    = x_coord_q;
    data_valid_d = 1'b0;

    if (frame_start && (state_q != StPublish)) begin
      // New frame start; from a capture state this discards the partial frame.
      state_d    = StCapY;
      shift_d    = '0;
      bit_cnt_d  = '0;
      pen_lost_d = 1'b0;
    end else begin
      if ((state_q == StCapY || state_q == StWaitX || state_q == StCapX) && penirq_sync_q) begin
        pen_lost_d = 1'b1;
      end
      unique case (state_q)
        StIdle: ;
        StCapY: begin
          if (y_sample) begin
            if (last_bit) begin
              y_hold_d  = shift_in;
              shift_d   = '0;
              bit_cnt_d = '0;
              state_d   = StWaitX;
            end else begin
              shift_d   = shift_in;
              bit_cnt_d = bit_cnt_q + CntW'(1);
            end
          end
        end
        StWaitX: begin
          // The transition cycle also takes the X MSB.
          if (x_first) begin
            shift_d   = shift_in;
            bit_cnt_d = CntW'(1);
            state_d   = StCapX;
          end
        end
        StCapX: begin
          if (x_sample) begin
            shift_d = shift_in;
            if (last_bit) begin
              bit_cnt_d = '0;
              state_d   = StPublish;
            end else begin
              bit_cnt_d = bit_cnt_q + CntW'(1);
            end
          end
        end
        StPublish: begin
          if (!pen_lost_q) begin
            y_coord_d    = y_hold_q;
            x_coord_d    = shift_q;
            data_valid_d = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      y_hold_q     <= '0;
      pen_lost_q   <= 1'b0;
      y_coord_q    <= '0;
      x_coord_q    <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      y_hold_q     <= y_hold_d;
      pen_lost_q   <= pen_lost_d;
      y_coord_q    <= y_coord_d;
      x_coord_q    <= x_coord_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign Y_COORD    = y_coord_q;
  assign X_COORD    = x_coord_q;
  assign DATA_VALID = data_valid_q;

endmodule

// File: tb/tb_adc_dout_capture.sv
// Testbench for adc_dout_capture: directed frames with a scoreboard of expected pairs.
module tb_adc_dout_capture;

  logic        CLK;
  logic        RST_n;
  logic        ENABLE;
  logic [6:0]  COUNT;
  logic        ADC_DOUT;
  logic        PENIRQ_n;
  logic [11:0] Y_COORD;
  logic [11:0] X_COORD;
  logic        DATA_VALID;
  logic        PEN_DOWN;

  typedef struct packed {
    logic [11:0] y;
    logic [11:0] x;
  } pair_t;

  pair_t       exp_q[$];
  pair_t       got_p;
  logic [11:0] last_y;
  logic [11:0] last_x;
  logic        prev_dv;
  int          checks;
  int          errors;

  adc_dout_capture #(
    .Y_FIRST(19),
    .X_FIRST(51),
    .NBITS  (12)
  ) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .ENABLE    (ENABLE),
    .COUNT     (COUNT),
    .ADC_DOUT  (ADC_DOUT),
    .PENIRQ_n  (PENIRQ_n),
    .Y_COORD   (Y_COORD),
    .X_COORD   (X_COORD),
    .DATA_VALID(DATA_VALID),
    .PEN_DOWN  (PEN_DOWN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // ADC model: Y bit (11-k) at COUNT 19+2k, X bit (11-k) at COUNT 51+2k, noise elsewhere.
  function automatic logic dout_for(input int c, input logic [11:0] y, input logic [11:0] x);
    int idx;
    if (c >= 19 && c <= 41 && (c % 2) == 1) begin
      idx = 11 - (c - 19) / 2;
      return y[idx];
    end else if (c >= 51 && c <= 73 && (c % 2) == 1) begin
      idx = 11 - (c - 51) / 2;
      return x[idx];
    end
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one frame from COUNT 0 to last_c; optional ENABLE gaps and pen lift at 40..44.
  task automatic run_frame(input logic [11:0] y, input logic [11:0] x, input int last_c,
                           input bit gaps, input bit pen_lift, input bit expect_pub);
    pair_t p;
    if (expect_pub) begin
      p.y = y;
      p.x = x;
      exp_q.push_back(p);
      last_y = y;
      last_x = x;
    end
    for (int c = 0; c <= last_c; c++) begin
      @(negedge CLK);
      COUNT    = 7'(c);
      ENABLE   = 1'b1;
      ADC_DOUT = dout_for(c, y, x);
      PENIRQ_n = pen_lift && (c >= 40) && (c <= 44);
      if (pen_lift && c == 44) check("pen_up_status", 32'(PEN_DOWN), 32'd0);
      if (pen_lift && c == 52) check("pen_down_again", 32'(PEN_DOWN), 32'd1);
      if (gaps) begin
        repeat (3) begin
          @(negedge CLK);
          ENABLE   = 1'b0;
          COUNT    = 7'($urandom_range(0, 127));
          ADC_DOUT = 1'($urandom_range(0, 1));
        end
      end
    end
  endtask

  // Monitor: every DATA_VALID pulse pops and compares one expected pair.
  initial begin
    prev_dv = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (RST_n && DATA_VALID) begin
        check("dv_single_cycle", 32'(prev_dv), 32'd0);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse got Y=%h X=%h want no pulse", Y_COORD, X_COORD);
        end else begin
          got_p = exp_q.pop_front();
          check("y_coord", 32'(Y_COORD), 32'(got_p.y));
          check("x_coord", 32'(X_COORD), 32'(got_p.x));
        end
      end
      prev_dv = DATA_VALID;
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    last_y   = '0;
    last_x   = '0;
    RST_n    = 1'b0;
    ENABLE   = 1'b0;
    COUNT    = '0;
    ADC_DOUT = 1'b0;
    PENIRQ_n = 1'b0;

    // Reset held with toggling inputs.
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      ENABLE   = 1'($urandom_range(0, 1));
      COUNT    = 7'($urandom_range(0, 127));
      ADC_DOUT = 1'($urandom_range(0, 1));
      PENIRQ_n = 1'($urandom_range(0, 1));
      #1;
      check("reset_outputs", {6'd0, Y_COORD, X_COORD, DATA_VALID, PEN_DOWN}, 32'd0);
    end
    @(negedge CLK);
    RST_n    = 1'b1;
    ENABLE   = 1'b0;
    PENIRQ_n = 1'b0;
    repeat (4) @(negedge CLK);
    check("pen_down_sync", 32'(PEN_DOWN), 32'd1);

    // Nominal frame.
    run_frame(12'hA5C, 12'h3F1, 127, 1'b0, 1'b0, 1'b1);
    // Extremes, back to back.
    run_frame(12'h000, 12'hFFF, 127, 1'b0, 1'b0, 1'b1);
    run_frame(12'hFFF, 12'h001, 127, 1'b0, 1'b0, 1'b1);

    // Pen lifted: no publish, previous pair held, then a clean frame.
    run_frame(12'h123, 12'h456, 127, 1'b0, 1'b1, 1'b0);
    check("hold_y", 32'(Y_COORD), 32'(last_y));
    check("hold_x", 32'(X_COORD), 32'(last_x));
    run_frame(12'h5A5, 12'h0F0, 127, 1'b0, 1'b0, 1'b1);

    // Abort mid-Y, then full frame.
    run_frame(12'hFFF, 12'hFFF, 30, 1'b0, 1'b0, 1'b0);
    run_frame(12'h777, 12'h888, 127, 1'b0, 1'b0, 1'b1);

    // ENABLE gaps with noise on COUNT and ADC_DOUT while low.
    run_frame(12'h9C3, 12'h2B6, 127, 1'b1, 1'b0, 1'b1);

    // Async reset mid-frame, then a fresh frame.
    run_frame(12'hABC, 12'hDEF, 60, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    ENABLE = 1'b0;
    RST_n  = 1'b0;
    #1;
    check("midframe_reset", {6'd0, Y_COORD, X_COORD, DATA_VALID, PEN_DOWN}, 32'd0);
    @(negedge CLK);
    RST_n  = 1'b1;
    last_y = '0;
    last_x = '0;
    run_frame(12'h456, 12'h123, 127, 1'b0, 1'b0, 1'b1);

    @(negedge CLK);
    ENABLE = 1'b0;
    repeat (6) @(negedge CLK);
    check("pending_pulses", 32'(exp_q.size()), 32'd0);
    check("final_y", 32'(Y_COORD), 32'h456);
    check("final_x", 32'(X_COORD), 32'h123);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
